// File: rtl/axi_sram_slave.sv
// AXI3 burst slave in front of a word-addressed on-chip RAM with independent read and write channels.
// Optional macro AXI_SLV_BUBBLE_EN inserts LFSR-driven read-launch and wready bubbles for stress testing.
module axi_sram_slave #(
    parameter int MEM_AW = 12
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int DEPTH = 2 ** MEM_AW;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [2:0] SIZE_WORD   = 3'b010;

    typedef enum logic {R_IDLE, R_BURST} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    logic [31:0] mem [DEPTH];

    function automatic logic [MEM_AW-1:0] step_addr(input logic [MEM_AW-1:0] a,
                                                   input logic [1:0] burst,
                                                   input logic [3:0] len);
        logic [MEM_AW-1:0] mask;
        logic [MEM_AW-1:0] inc;
        mask = MEM_AW'(len);
        inc  = a + MEM_AW'(1);
        case (burst)
            BURST_FIXED: step_addr = a;
            BURST_WRAP:  step_addr = (a & ~mask) | (inc & mask);
            default:     step_addr = inc;
        endcase
    endfunction

    function automatic logic bad_burst(input logic [1:0] burst, input logic [3:0] len);
        bad_burst = (burst == 2'b11) ||
                    (burst == BURST_WRAP &&
                     !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15));
    endfunction

    logic r_stall;
    logic w_stall;

`ifdef AXI_SLV_BUBBLE_EN
    logic [15:0] lfsr;
    logic [15:0] lfsr_nxt;

    assign lfsr_nxt = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    assign r_stall  = lfsr[0];
    // wready is registered, so it is computed from the value lfsr will hold next cycle
    assign w_stall  = lfsr_nxt[1];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) lfsr <= 16'hACE1;
        else          lfsr <= lfsr_nxt;
    end
`else
    assign r_stall = 1'b0;
    assign w_stall = 1'b0;
`endif

    // Read channel
    r_state_t          r_state;
    logic [MEM_AW-1:0] r_addr;
    logic [3:0]        r_len;
    logic [3:0]        r_cnt;
    logic [1:0]        r_burst;
    logic              r_size_bad;
    logic [MEM_AW-1:0] ar_idx;
    logic [1:0]        ar_burst_eff;
    logic              ar_err;
    logic              launch_next;

    assign ar_idx       = araddr[MEM_AW+1:2];
    assign ar_burst_eff = bad_burst(arburst, arlen) ? BURST_INCR : arburst;
    assign ar_err       = (arsize != SIZE_WORD) || bad_burst(arburst, arlen);
    assign launch_next  = (r_state == R_BURST) && !(rvalid && rlast) &&
                          (!rvalid || rready) && !r_stall;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state    <= R_IDLE;
            arready    <= 1'b1;
            rvalid     <= 1'b0;
            rlast      <= 1'b0;
            rresp      <= RESP_OKAY;
            rid        <= '0;
            rdata      <= '0;
            r_addr     <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_burst    <= BURST_INCR;
            r_size_bad <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (arvalid && arready) begin
                        rid        <= arid;
                        r_len      <= arlen;
                        r_cnt      <= '0;
                        r_burst    <= ar_burst_eff;
                        r_size_bad <= (arsize != SIZE_WORD);
                        rdata      <= (arsize != SIZE_WORD) ? 32'h0 : mem[ar_idx];
                        rresp      <= ar_err ? RESP_SLVERR : RESP_OKAY;
                        rlast      <= (arlen == 4'd0);
                        rvalid     <= 1'b1;
                        arready    <= 1'b0;
                        r_addr     <= step_addr(ar_idx, ar_burst_eff, arlen);
                        r_state    <= R_BURST;
                    end
                end
                default: begin
                    if (rvalid && rready && rlast) begin
                        rvalid  <= 1'b0;
                        rlast   <= 1'b0;
                        arready <= 1'b1;
                        r_state <= R_IDLE;
                    end else if (launch_next) begin
                        rvalid <= 1'b1;
                        rdata  <= r_size_bad ? 32'h0 : mem[r_addr];
                        rlast  <= (r_cnt + 4'd1 == r_len);
                        r_cnt  <= r_cnt + 4'd1;
                        r_addr <= step_addr(r_addr, r_burst, r_len);
                    end else if (rvalid && rready) begin
                        rvalid <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Write channel
    w_state_t          w_state;
    logic [MEM_AW-1:0] w_addr;
    logic [3:0]        w_len;
    logic [3:0]        w_cnt;
    logic [1:0]        w_burst;
    logic              w_err;
    logic              w_fire;

    assign w_fire = (w_state == W_DATA) && wvalid && wready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state <= W_IDLE;
            awready <= 1'b1;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
            bid     <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_burst <= BURST_INCR;
            w_err   <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (awvalid && awready) begin
                        bid     <= awid;
                        w_addr  <= awaddr[MEM_AW+1:2];
                        w_len   <= awlen;
                        w_cnt   <= '0;
                        w_burst <= bad_burst(awburst, awlen) ? BURST_INCR : awburst;
                        w_err   <= (awsize != SIZE_WORD) || bad_burst(awburst, awlen);
                        awready <= 1'b0;
                        wready  <= !w_stall;
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire && wlast) begin
                        wready  <= 1'b0;
                        bvalid  <= 1'b1;
                        bresp   <= (w_err || w_cnt != w_len) ? RESP_SLVERR : RESP_OKAY;
                        w_state <= W_RESP;
                    end else begin
                        if (w_fire) begin
                            w_cnt  <= w_cnt + 4'd1;
                            w_addr <= step_addr(w_addr, w_burst, w_len);
                        end
                        wready <= !w_stall;
                    end
                end
                default: begin
                    if (bvalid && bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
            endcase
        end
    end

    // RAM is never reset; a read launched in the same cycle as a write sees the old word
    always_ff @(posedge aclk) begin
        if (w_fire && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) mem[w_addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    logic unused_ok;
    assign unused_ok = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid,
                         araddr[31:MEM_AW+2], araddr[1:0], awaddr[31:MEM_AW+2], awaddr[1:0]};

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: transaction-level memory model plus an always-on read beat checker.
module tb_axi_sram_slave;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [3:0]  arid, awid, wid, rid, bid;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [3:0]  arlen, awlen, arcache, awcache, wstrb;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    always #5 aclk = ~aclk;

    axi_sram_slave #(.MEM_AW(12)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] model_mem [4096];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    int          vectors = 0;
    int          miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic burst_bad(input logic [1:0] burst, input int len);
        return (burst == 2'b11) || (burst == 2'b10 && !(len inside {1, 3, 7, 15}));
    endfunction

    // Word index of beat i, from the AXI address rules
    function automatic int beat_addr(input logic [31:0] addr, input int len,
                                     input logic [1:0] burst, input int i);
        int w, n;
        w = int'(addr[13:2]);
        n = len + 1;
        if (burst_bad(burst, len) || burst == 2'b01) return (w + i) % 4096;
        if (burst == 2'b00) return w;
        return (w - (w % n)) + ((w % n) + i) % n;
    endfunction

    task automatic check_reset_state();
        check("rst_arready", arready, 1);
        check("rst_awready", awready, 1);
        check("rst_rvalid", rvalid, 0);
        check("rst_rlast", rlast, 0);
        check("rst_rresp", rresp, 0);
        check("rst_rid", rid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_wready", wready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_bresp", bresp, 0);
        check("rst_bid", bid, 0);
    endtask

    // Read beat checker: every presented beat must equal the head of the expected queue
    always @(negedge aclk) begin
        if (aresetn === 1'b1 && rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("r_unexpected_beat", rvalid, 0);
            end else begin
                check("rdata", rdata, exp_q[0].data);
                check("rresp", rresp, exp_q[0].resp);
                check("rlast", rlast, exp_q[0].last);
                check("rid", rid, exp_q[0].id);
            end
        end
    end

    always @(posedge aclk) begin
        if (aresetn === 1'b1 && rvalid === 1'b1 && rready === 1'b1 && exp_q.size() > 0)
            void'(exp_q.pop_front());
    end

    task automatic axi_write(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                             input logic [2:0] size, input logic [3:0] id, input int nbeats);
        int t;
        logic bad;
        logic [1:0] eresp;
        int a;
        bad   = (size != 3'b010) || burst_bad(burst, int'(len));
        eresp = (bad || (nbeats - 1) != int'(len)) ? 2'b10 : 2'b00;
        @(negedge aclk);
        awaddr = addr; awlen = len; awburst = burst; awsize = size; awid = id; awvalid = 1'b1;
        t = 0;
        while (!awready && t < 50) begin @(negedge aclk); t++; end
        check("aw_ready", awready, 1);
        @(negedge aclk);
        awvalid = 1'b0;
        check("aw_busy", awready, 0);
        for (int i = 0; i < nbeats; i++) begin
            wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i]; wlast = (i == nbeats - 1);
            t = 0;
            while (!wready && t < 50) begin @(negedge aclk); t++; end
            check("w_ready", wready, 1);
            @(negedge aclk);
            if (!bad) begin
                a = beat_addr(addr, int'(len), burst, i);
                for (int b = 0; b < 4; b++)
                    if (ws[i][b]) model_mem[a][8*b +: 8] = wd[i][8*b +: 8];
            end
        end
        wvalid = 1'b0; wlast = 1'b0;
        check("b_valid", bvalid, 1);
        check("b_resp", bresp, eresp);
        check("b_id", bid, id);
        @(negedge aclk);
        check("b_hold", bvalid, 1);
        check("w_ready_in_resp", wready, 0);
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
        check("b_done", bvalid, 0);
        check("aw_ready_idle", awready, 1);
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                            input logic [2:0] size, input logic [3:0] id,
                            input int stall_at, input int abort_at);
        int t;
        logic bad, sbad;
        beat_t bt;
        sbad = (size != 3'b010);
        bad  = sbad || burst_bad(burst, int'(len));
        @(negedge aclk);
        araddr = addr; arlen = len; arburst = burst; arsize = size; arid = id; arvalid = 1'b1;
        t = 0;
        while (!arready && t < 50) begin @(negedge aclk); t++; end
        check("ar_ready", arready, 1);
        for (int i = 0; i <= int'(len); i++) begin
            bt.data = sbad ? 32'h0 : model_mem[beat_addr(addr, int'(len), burst, i)];
            bt.resp = bad ? 2'b10 : 2'b00;
            bt.last = (i == int'(len));
            bt.id   = id;
            exp_q.push_back(bt);
        end
        @(negedge aclk);
        arvalid = 1'b0;
        check("r_first_latency", rvalid, 1);
        check("ar_busy", arready, 0);
        for (int i = 0; i <= int'(len); i++) begin
            if (i == abort_at) begin
                aresetn = 1'b0;
                #1;
                check("r_abort_rvalid", rvalid, 0);
                exp_q.delete();
                check_reset_state();
                @(negedge aclk);
                @(negedge aclk);
                aresetn = 1'b1;
                return;
            end
            if (i == stall_at) begin
                rready = 1'b0;
                repeat (3) @(negedge aclk);
                check("r_stall_hold", rvalid, 1);
                rready = 1'b1;
            end
            @(negedge aclk);
            if (i < int'(len)) begin
                check("r_back_to_back", rvalid, 1);
            end else begin
                check("r_end_rvalid", rvalid, 0);
                check("ar_ready_after", arready, 1);
                check("r_all_beats", exp_q.size(), 0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        aresetn = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = 3'b010; arburst = 2'b01;
        arlock = '0; arcache = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awsize = 3'b010; awburst = 2'b01;
        awlock = '0; awcache = '0; awprot = '0; awvalid = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        repeat (3) @(negedge aclk);
        check_reset_state();
        aresetn = 1'b1;

        // 8-beat INCR write then readback
        for (int i = 0; i < 8; i++) begin wd[i] = 32'(i + 1) * 32'h11; ws[i] = 4'hF; end
        axi_write(32'h100, 4'd7, 2'b01, 3'b010, 4'd5, 8);
        check("model_word40", model_mem[12'h040], 32'h0000_0011);
        check("model_word47", model_mem[12'h047], 32'h0000_0088);
        axi_read(32'h100, 4'd7, 2'b01, 3'b010, 4'd9, -1, -1);

        // Byte strobes and a reserved-burst write that must not touch RAM
        wd[0] = 32'h1122_3344; ws[0] = 4'hF;
        axi_write(32'h200, 4'd0, 2'b01, 3'b010, 4'd3, 1);
        wd[0] = 32'hAABB_CCDD; ws[0] = 4'b0101;
        axi_write(32'h200, 4'd0, 2'b01, 3'b010, 4'd4, 1);
        check("model_strb", model_mem[12'h080], 32'h11BB_33DD);
        axi_read(32'h200, 4'd0, 2'b01, 3'b010, 4'd4, -1, -1);
        wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
        axi_write(32'h200, 4'd0, 2'b11, 3'b010, 4'd6, 1);
        axi_read(32'h200, 4'd0, 2'b01, 3'b010, 4'd6, -1, -1);

        // Backpressure on beat 3
        axi_read(32'h100, 4'd7, 2'b01, 3'b010, 4'd2, 2, -1);

        // WRAP, bad size, bad wrap length, reserved burst
        check("wrap_beat0", beat_addr(32'h10C, 3, 2'b10, 0), 32'h43);
        check("wrap_beat1", beat_addr(32'h10C, 3, 2'b10, 1), 32'h40);
        axi_read(32'h10C, 4'd3, 2'b10, 3'b010, 4'd7, -1, -1);
        axi_read(32'h10C, 4'd3, 2'b10, 3'b001, 4'd7, -1, -1);
        axi_read(32'h104, 4'd2, 2'b10, 3'b010, 4'd1, -1, -1);
        axi_read(32'h100, 4'd1, 2'b11, 3'b010, 4'd1, -1, -1);

        // INCR wraps modulo depth
        wd[0] = 32'h0000_00A1; wd[1] = 32'h0000_00B2; ws[0] = 4'hF; ws[1] = 4'hF;
        axi_write(32'h3FFC, 4'd1, 2'b01, 3'b010, 4'd8, 2);
        check("model_mod_wrap", model_mem[0], 32'h0000_00B2);
        axi_read(32'h3FFC, 4'd1, 2'b01, 3'b010, 4'd8, -1, -1);

        // FIXED burst keeps one word
        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
        axi_write(32'h400, 4'd3, 2'b00, 3'b010, 4'd10, 4);
        axi_read(32'h400, 4'd1, 2'b00, 3'b010, 4'd10, -1, -1);

        // Early wlast: SLVERR, data still written
        wd[0] = 32'h55; wd[1] = 32'h66; ws[0] = 4'hF; ws[1] = 4'hF;
        axi_write(32'h300, 4'd3, 2'b01, 3'b010, 4'd11, 2);
        axi_read(32'h300, 4'd1, 2'b01, 3'b010, 4'd11, -1, -1);

        // Reset in the middle of a read burst, then a clean read
        axi_read(32'h100, 4'd7, 2'b01, 3'b010, 4'd12, -1, 3);
        check_reset_state();
        axi_read(32'h100, 4'd7, 2'b01, 3'b010, 4'd13, -1, -1);

        repeat (2) @(negedge aclk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
